// File: rtl/map_pkg.sv
// ---------------------------------------------------------------------------
// map_pkg
// Shared types and default constants for the occupancy map update path.
//   cell_t       : signed log-odds cell at the default width
//   map_state_t  : updater FSM states (ACTIVE, CLEARING)
//   MAP_*        : default geometry and log-odds increments/bounds
// ---------------------------------------------------------------------------
package map_pkg;

    localparam int MAP_ADDR_WIDTH = 10;   // 32x32 grid
    localparam int MAP_DATA_WIDTH = 8;
    localparam int MAP_L_OCC      = 8;
    localparam int MAP_L_FREE     = 3;
    localparam int MAP_L_MAX      = 100;
    localparam int MAP_L_MIN      = -100;

    typedef logic signed [MAP_DATA_WIDTH-1:0] cell_t;

    typedef enum logic {
        ACTIVE   = 1'b0,
        CLEARING = 1'b1
    } map_state_t;

endpackage

// File: rtl/log_odds_saturate.sv
// ---------------------------------------------------------------------------
// log_odds_saturate
// Combinational log-odds step: adds +L_OCC (occupied) or -L_FREE (free) to a
// signed cell value and clamps the result to [L_MIN, L_MAX].
//   cell_i    in  DATA_WIDTH : current signed cell value
//   is_free_i in  1          : 1 = subtract L_FREE, 0 = add L_OCC
//   cell_o    out DATA_WIDTH : updated, saturated cell value
// ---------------------------------------------------------------------------
module log_odds_saturate
    import map_pkg::*;
#(
    parameter int DATA_WIDTH = MAP_DATA_WIDTH,
    parameter int L_OCC      = MAP_L_OCC,
    parameter int L_FREE     = MAP_L_FREE,
    parameter int L_MAX      = MAP_L_MAX,
    parameter int L_MIN      = MAP_L_MIN
) (
    input  logic [DATA_WIDTH-1:0] cell_i,
    input  logic                  is_free_i,
    output logic [DATA_WIDTH-1:0] cell_o
);

    localparam logic signed [DATA_WIDTH:0] OCC_W  = (DATA_WIDTH+1)'(L_OCC);
    localparam logic signed [DATA_WIDTH:0] FREE_W = (DATA_WIDTH+1)'(L_FREE);
    localparam logic signed [DATA_WIDTH:0] MAX_W  = (DATA_WIDTH+1)'(L_MAX);
    localparam logic signed [DATA_WIDTH:0] MIN_W  = (DATA_WIDTH+1)'(L_MIN);

    logic signed [DATA_WIDTH:0] ext;
    logic signed [DATA_WIDTH:0] delta;
    logic signed [DATA_WIDTH:0] sum;

    // One extra bit of headroom keeps the sum exact; the clamp also pulls
    // stored values that already sit outside the bounds back into range.
    always_comb begin
        ext   = {cell_i[DATA_WIDTH-1], cell_i};
        delta = is_free_i ? -FREE_W : OCC_W;
        sum   = ext + delta;
        if (sum > MAX_W) begin
            cell_o = MAX_W[DATA_WIDTH-1:0];
        end else if (sum < MIN_W) begin
            cell_o = MIN_W[DATA_WIDTH-1:0];
        end else begin
            cell_o = sum[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/occupancy_map_updater.sv
// ---------------------------------------------------------------------------
// occupancy_map_updater
// Two-stage read-modify-write of log-odds cells in a simple dual-port RAM,
// one update per cycle, plus a whole-map clear sweep.
//   clock, reset        : rising-edge clock, async active-low reset
//   req_valid/req_ready : update request handshake
//   req_addr, req_is_free : target cell and free/occupied tag
//   clear               : pulse requesting a whole-map zero sweep
//   busy                : update in flight, clear pending or sweep active
//   mem_rd_en/addr/data : RAM read port (data one cycle after strobe)
//   mem_we/wr_addr/wr_data : RAM write port
// ---------------------------------------------------------------------------
module occupancy_map_updater
    import map_pkg::*;
#(
    parameter int ADDR_WIDTH = MAP_ADDR_WIDTH,
    parameter int DATA_WIDTH = MAP_DATA_WIDTH,
    parameter int L_OCC      = MAP_L_OCC,
    parameter int L_FREE     = MAP_L_FREE,
    parameter int L_MAX      = MAP_L_MAX,
    parameter int L_MIN      = MAP_L_MIN
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_is_free,
    input  logic                  clear,
    output logic                  busy,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data
);

    map_state_t state_q, state_d;

    logic                  clear_pending_q, clear_pending_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic                  s1_valid_q, s1_valid_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic                  s1_free_q, s1_free_d;

    // Copy of the previous cycle's write, used to bypass the RAM's
    // old-data behaviour on read-during-write.
    logic                  fwd_valid_q;
    logic [ADDR_WIDTH-1:0] fwd_addr_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    logic                  accept;
    logic                  sweep_last;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] upd_data;

    log_odds_saturate #(
        .DATA_WIDTH (DATA_WIDTH),
        .L_OCC      (L_OCC),
        .L_FREE     (L_FREE),
        .L_MAX      (L_MAX),
        .L_MIN      (L_MIN)
    ) u_sat (
        .cell_i    (operand),
        .is_free_i (s1_free_q),
        .cell_o    (upd_data)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        sweep_last = (state_q == CLEARING) && (cnt_q == '1);
        state_d    = state_q;
        case (state_q)
            ACTIVE: begin
                // Sweep starts only once the update stage has drained.
                if ((clear || clear_pending_q) && !s1_valid_q) begin
                    state_d = CLEARING;
                end
            end
            CLEARING: begin
                if (sweep_last) begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // ---------------- FSM: outputs / datapath ----------------
    always_comb begin
        req_ready   = (state_q == ACTIVE) && !clear_pending_q && !clear;
        accept      = req_valid && req_ready;
        mem_rd_en   = accept;
        mem_rd_addr = req_addr;

        operand = (fwd_valid_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q
                                                             : mem_rd_data;

        if (state_q == CLEARING) begin
            mem_we      = 1'b1;
            mem_wr_addr = cnt_q;
            mem_wr_data = '0;
        end else begin
            mem_we      = s1_valid_q;
            mem_wr_addr = s1_addr_q;
            mem_wr_data = upd_data;
        end

        busy = s1_valid_q || clear_pending_q || (state_q == CLEARING);
    end

    // ---------------- pipeline / sweep next state ----------------
    always_comb begin
        s1_valid_d = accept;
        s1_addr_d  = accept ? req_addr    : s1_addr_q;
        s1_free_d  = accept ? req_is_free : s1_free_q;

        clear_pending_d = clear_pending_q;
        if (sweep_last) begin
            clear_pending_d = 1'b0;
        end else if (clear && (state_q == ACTIVE)) begin
            clear_pending_d = 1'b1;
        end

        cnt_d = (state_q == CLEARING) ? cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clear_pending_q <= 1'b0;
            cnt_q           <= '0;
            s1_valid_q      <= 1'b0;
            s1_addr_q       <= '0;
            s1_free_q       <= 1'b0;
            fwd_valid_q     <= 1'b0;
            fwd_addr_q      <= '0;
            fwd_data_q      <= '0;
        end else begin
            clear_pending_q <= clear_pending_d;
            cnt_q           <= cnt_d;
            s1_valid_q      <= s1_valid_d;
            s1_addr_q       <= s1_addr_d;
            s1_free_q       <= s1_free_d;
            fwd_valid_q     <= mem_we;
            fwd_addr_q      <= mem_wr_addr;
            fwd_data_q      <= mem_wr_data;
        end
    end

endmodule

// File: tb/tb_occupancy_map_updater.sv
// ---------------------------------------------------------------------------
// tb_occupancy_map_updater
// Bench for occupancy_map_updater with a behavioural dual-port RAM
// (registered read, old data on read-during-write) and a write scoreboard.
// ---------------------------------------------------------------------------
module tb_occupancy_map_updater;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [9:0] req_addr;
    logic       req_is_free;
    logic       clear;
    logic       busy;
    logic       mem_rd_en;
    logic [9:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       mem_we;
    logic [9:0] mem_wr_addr;
    logic [7:0] mem_wr_data;

    // preload port into the RAM model
    logic       pl_en;
    logic [9:0] pl_addr;
    logic [7:0] pl_data;

    logic [7:0] ram [0:1023];

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int addr;
        bit is_free;
        int init;
        int exp;
    } vec_t;

    wr_t  sb[$];
    wr_t  w;
    vec_t tbl[10];

    int n_checks = 0;
    int n_errors = 0;

    occupancy_map_updater #(
        .ADDR_WIDTH (10),
        .DATA_WIDTH (8),
        .L_OCC      (8),
        .L_FREE     (3),
        .L_MAX      (100),
        .L_MIN      (-100)
    ) dut (
        .clock       (clk),
        .reset       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_is_free (req_is_free),
        .clear       (clear),
        .busy        (busy),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_data;
        end else if (mem_we) begin
            ram[mem_wr_addr] <= mem_wr_data;
        end
        if (mem_rd_en) begin
            mem_rd_data <= ram[mem_rd_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every RAM write must match the next expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", int'(mem_wr_addr), -1);
            end else begin
                w = sb.pop_front();
                chk("wr_addr", int'(mem_wr_addr), w.addr);
                chk("wr_data", $signed(mem_wr_data), w.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input int addr, input int val);
        pl_en   = 1'b1;
        pl_addr = 10'(addr);
        pl_data = 8'(val);
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input int addr, input bit is_free, input int exp);
        sb.push_back('{addr, exp});
        req_valid   = 1'b1;
        req_addr    = 10'(addr);
        req_is_free = is_free;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int  bad;
        bit  found;

        req_valid   = 1'b0;
        req_addr    = '0;
        req_is_free = 1'b0;
        clear       = 1'b0;
        pl_en       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        rst_n       = 1'b0;

        tbl[0] = '{5,   1'b0,    0,    8};
        tbl[1] = '{7,   1'b0,   98,  100};
        tbl[2] = '{8,   1'b1,  -99, -100};
        tbl[3] = '{9,   1'b1,  120,  100};
        tbl[4] = '{10,  1'b1, -128, -100};
        tbl[5] = '{11,  1'b0,  127,  100};
        tbl[6] = '{12,  1'b0, -128, -100};
        tbl[7] = '{13,  1'b1,   50,   47};
        tbl[8] = '{14,  1'b0,   -5,    3};
        tbl[9] = '{15,  1'b1, -101, -100};

        // ---------------- reset ----------------
        @(negedge clk);
        @(negedge clk);
        chk("reset_mem_we",    int'(mem_we),    0);
        chk("reset_mem_rd_en", int'(mem_rd_en), 0);
        chk("reset_busy",      int'(busy),      0);
        chk("reset_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        chk("idle_after_reset_bad_cycles", bad, 0);
        @(posedge clk);
        #1;

        // ---------------- single update, cycle by cycle ----------------
        preload(5, 0);
        sb.push_back('{5, 8});
        req_valid   = 1'b1;
        req_addr    = 10'd5;
        req_is_free = 1'b0;
        @(negedge clk);
        chk("single_rd_en",   int'(mem_rd_en),   1);
        chk("single_rd_addr", int'(mem_rd_addr), 5);
        chk("single_ready",   int'(req_ready),   1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("single_we_t1",   int'(mem_we),      1);
        chk("single_busy_t1", int'(busy),        1);
        @(negedge clk);
        chk("single_busy_t2", int'(busy),        0);
        chk("single_we_t2",   int'(mem_we),      0);
        @(posedge clk);
        #1;

        // ---------------- table of isolated updates ----------------
        for (int i = 0; i < 10; i++) begin
            preload(tbl[i].addr + 100, tbl[i].init);
            issue(tbl[i].addr + 100, tbl[i].is_free, tbl[i].exp);
            idle(3);
        end

        // ---------------- back-to-back forwarding ----------------
        preload(3, 0);
        issue(3, 1'b1, -3);
        issue(3, 1'b1, -6);
        issue(3, 1'b1, -9);
        idle(3);

        // A,B,A: forwarding must only cover the immediately preceding write
        preload(30, 0);
        preload(31, 0);
        issue(30, 1'b0, 8);
        issue(31, 1'b0, 8);
        issue(30, 1'b0, 16);
        idle(3);

        // ---------------- clear arriving with an update in flight ----------------
        preload(4, 10);
        issue(4, 1'b0, 18);
        clear = 1'b1;
        for (int a = 0; a < 1024; a++) sb.push_back('{a, 0});
        @(negedge clk);
        chk("clear_cycle_ready", int'(req_ready), 0);
        chk("clear_cycle_busy",  int'(busy),      1);
        @(posedge clk);
        #1;
        clear = 1'b0;
        bad   = 0;
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || busy !== 1'b1) bad++;
            if (mem_we === 1'b1 && mem_wr_addr == 10'd1023) begin
                found = 1'b1;
                break;
            end
        end
        chk("sweep_reached_1023", int'(found), 1);
        chk("sweep_ready_busy_bad_cycles", bad, 0);
        @(negedge clk);
        chk("post_sweep_ready", int'(req_ready), 1);
        chk("post_sweep_busy",  int'(busy),      0);
        chk("post_sweep_sb_empty", sb.size(), 0);
        @(posedge clk);
        #1;

        // ---------------- reset in the middle of a sweep ----------------
        idle(2);
        clear = 1'b1;
        for (int a = 0; a <= 300; a++) sb.push_back('{a, 0});
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        chk("first_sweep_we",   int'(mem_we),      1);
        chk("first_sweep_addr", int'(mem_wr_addr), 0);
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            clear = 1'b0;
            // a second clear during the sweep must not restart it
            if (mem_we === 1'b1 && mem_wr_addr == 10'd100) clear = 1'b1;
            if (mem_we === 1'b1 && mem_wr_addr == 10'd300) begin
                found = 1'b1;
                break;
            end
        end
        clear = 1'b0;
        chk("sweep_reached_300", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midclear_reset_we",    int'(mem_we),    0);
        chk("midclear_reset_busy",  int'(busy),      0);
        chk("midclear_reset_ready", int'(req_ready), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_ready", int'(req_ready), 1);
        chk("after_reset_we",    int'(mem_we),    0);
        issue(20, 1'b0, 8);
        idle(3);

        chk("final_sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/occupancy_map_updater.md
# occupancy_map_updater

Consumes the per-cell update stream produced by the Bresenham ray tracer (one cell per cycle, tagged free or occupied). Applies a saturating log-odds read-modify-write to the occupancy grid held in a simple dual-port RAM. Also provides a whole-map clear sweep. Sits between the Bresenham datapath and the map memory that the scan matcher reads.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: cell address width (32×32 grid).
- `DATA_WIDTH`, 8: signed log-odds cell width.
- `L_OCC`, 8: increment applied for an occupied cell.
- `L_FREE`, 3: decrement applied for a free cell.
- `L_MAX`, 100: upper saturation bound.
- `L_MIN`, -100: lower saturation bound.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `req_valid` in 1: cell update request.
- `req_ready` out 1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_addr` in ADDR_WIDTH: cell address.
- `req_is_free` in 1: 1 means free (subtract `L_FREE`); 0 means occupied (add `L_OCC`).
- `clear` in 1: single-cycle pulse that requests a whole-map clear.
- `busy` out 1: update in flight, clear pending, or clear sweep active.
- `mem_rd_en` out 1: RAM read strobe.
- `mem_rd_addr` out ADDR_WIDTH: RAM read address.
- `mem_rd_data` in DATA_WIDTH: RAM read data, valid one cycle after `mem_rd_en`.
- `mem_we` out 1: RAM write strobe.
- `mem_wr_addr` out ADDR_WIDTH: RAM write address.
- `mem_wr_data` out DATA_WIDTH: RAM write data.

## Operation
- FSM states: `ACTIVE` and `CLEARING`. Reset state is `ACTIVE`.
- Reset values: S1 stage invalid, `clear_pending` 0, sweep counter 0.
- Output values during reset: `mem_we` 0, `mem_rd_en` 0, `busy` 0, `req_ready` 1.
- Ready rule: `req_ready = (state==ACTIVE) && !clear_pending && !clear`. Clear wins over a simultaneous request.
- Read stage (combinational):
  - `mem_rd_en = req_valid && req_ready`.
  - `mem_rd_addr = req_addr`.
  - On acceptance, S1 registers addr and is_free and sets S1 valid.
- Modify/write stage (cycle after acceptance):
  - Operand is `mem_rd_data`, or the forwarded value when S1 addr equals the address written in the previous cycle. Forwarding is required because the RAM returns old data on read-during-write.
  - The sum is computed in DATA_WIDTH+1 signed bits, then clamped to [`L_MIN`, `L_MAX`]. Stored values outside that range are clamped as well.
  - `mem_we = S1 valid`; `mem_wr_addr` and `mem_wr_data` are combinational from S1 and the adder.
- Throughput: one update per cycle, with back-to-back same-address updates. Forwarding depth is exactly one write.
- Clear handling:
  - A `clear` pulse in `ACTIVE` sets `clear_pending`.
  - Once S1 is invalid (pipeline drained), the FSM enters `CLEARING` with counter 0.
  - Each cycle in `CLEARING`: `mem_we`=1, `mem_wr_addr`=counter, `mem_wr_data`=0.
  - After writing address 2^ADDR_WIDTH−1 (counter wraps), return to `ACTIVE` and drop `clear_pending`.
- `clear` asserted while already pending or in `CLEARING` is ignored.
- `busy = S1 valid || clear_pending || state==CLEARING`.
- Reset mid-operation: in-flight update and sweep are abandoned; outputs return to reset values immediately (asynchronous).

## Timing
- Update latency: accepted at edge t, read issued in cycle t, write driven in cycle t+1, committed at edge t+2.
- Clear latency: pulse at edge t with S1 empty gives first zero-write in cycle t+1. Sweep lasts 2^ADDR_WIDTH cycles. `req_ready` is high again in the cycle after the last write.
- If S1 is valid when clear arrives, its write completes first, then the sweep starts.
- `req_ready` is low from the `clear` cycle through the end of the sweep.

## Structure
- Package `map_pkg`:
  - `cell_t` signed typedef.
  - Default width and log-odds constants.
  - `map_state_t` enum (`ACTIVE`, `CLEARING`).
- Sub-module `log_odds_saturate`: combinational add of ±delta with clamp to [`L_MIN`, `L_MAX`]. Instantiated once.

## Test plan
- **Reset:** with `reset`=0, `mem_we`=0, `busy`=0, `req_ready`=1. Releasing reset changes nothing until a request arrives.
- **Single update:** cell 5 holds 0; occupied request at 5 → `mem_rd_addr`=5 in cycle t, `mem_we`=1 with addr 5, data 8 in t+1; `busy` low in t+2.
- **Forwarding:** cell 3 holds 0; three back-to-back free requests at 3 → writes −3, −6, −9 on consecutive cycles.
- **Saturation:** cell 7 holds 98, occupied → 100. Cell 8 holds −99, free → −100. Cell 9 holds 120, free → 100.
- **Clear mid-stream:** `clear` in the cycle after accepting a request at 4 → the write to 4 completes, then 1024 zero-writes to addresses 0..1023. Throughout, `req_ready`=0 and `busy`=1; `req_ready` returns to 1 afterwards.
- **Reset mid-clear:** assert `reset` at sweep address 300 → `mem_we`=0 immediately. After release, `req_ready`=1 and a new request is accepted.
